// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out handshake bundle for the 3x3 CNN neighbourhood generator.
interface cnn_window_gen_if #(
  parameter int DW    = 18,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
);
  localparam int RW  = $clog2(IMG_H);
  localparam int CLW = $clog2(IMG_W);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 win_valid;
  logic                 win_ready;
  logic signed [DW-1:0] W1, W2, W3, W4, W5, W6, W7, W8, W9;
  logic [RW-1:0]        win_row;
  logic [CLW-1:0]       win_col;
  logic                 frame_done;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, W1, W2, W3, W4, W5, W6, W7, W8, W9,
           win_row, win_col, frame_done
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, W1, W2, W3, W4, W5, W6, W7, W8, W9,
           win_row, win_col, frame_done
  );
endinterface

// File: rtl/cnn_window_gen.sv
// Streams a raster frame and emits one 3x3 neighbourhood per cell, out-of-frame taps
// replaced by BOUNDARY. History is a shift register of the last 2*IMG_W+2 pixels.
//
//   state  | meaning
//   IDLE   | one cycle after reset, nothing accepted
//   STREAM | accepting pixels, emitting windows as they are enabled
//   FLUSH  | whole frame stored, draining remaining windows, no input
module cnn_window_gen #(
  parameter int                   DW       = 18,
  parameter int                   IMG_W    = 16,
  parameter int                   IMG_H    = 16,
  parameter logic signed [DW-1:0] BOUNDARY = '0
) (
  input logic             clk,
  input logic             rst,
  cnn_window_gen_if.slave bus
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = 2 * IMG_W + 2;
  localparam int CW    = $clog2(NPIX + 1);
  localparam int RW    = $clog2(IMG_H);
  localparam int CLW   = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t               state;
  logic signed [DW-1:0] sr [DEPTH];
  logic signed [DW-1:0] cur [DEPTH+1];
  logic signed [DW-1:0] tap [9];
  logic signed [DW-1:0] w_q [9];
  logic [CW-1:0]        acc_cnt;
  logic [CW-1:0]        acc_after;
  logic [RW-1:0]        out_r, row_q;
  logic [CLW-1:0]       out_c, col_q;
  logic                 out_done;
  logic                 valid_q;
  logic                 hold, xfer, last_xfer, backlog, accept, load, in_ready_c;
  int                   en_cur;

  // Raster index of the pixel whose arrival releases window (r,c).
  function automatic int enable_idx(input logic [RW-1:0] r, input logic [CLW-1:0] c);
    int rr;
    int cc;
    rr = (int'(r) + 1 > IMG_H - 1) ? IMG_H - 1 : int'(r) + 1;
    cc = (int'(c) + 1 > IMG_W - 1) ? IMG_W - 1 : int'(c) + 1;
    return rr * IMG_W + cc;
  endfunction

  always_comb begin
    en_cur     = enable_idx(out_r, out_c);
    hold       = valid_q && !bus.win_ready;
    xfer       = valid_q && bus.win_ready;
    last_xfer  = xfer && (row_q == RW'(IMG_H - 1)) && (col_q == CLW'(IMG_W - 1));
    backlog    = !out_done && (int'(acc_cnt) > en_cur);
    in_ready_c = (state == STREAM) && !hold && !backlog;
    accept     = bus.in_valid && in_ready_c;
    acc_after  = acc_cnt + CW'(accept);
    load       = !hold && !out_done && (int'(acc_after) > en_cur);
  end

  // View of history as it stands after this cycle's pixel, cur[0] newest.
  always_comb begin
    cur[0] = accept ? bus.in_data : sr[0];
    for (int j = 1; j < DEPTH; j++) cur[j] = accept ? sr[j-1] : sr[j];
    cur[DEPTH] = sr[DEPTH-1];
  end

  always_comb begin
    int latest;
    int rr;
    int cc;
    int off;
    latest = int'(acc_after) - 1;
    rr     = 0;
    cc     = 0;
    off    = 0;
    for (int k = 0; k < 9; k++) begin
      tap[k] = BOUNDARY;
      rr     = int'(out_r) + k / 3 - 1;
      cc     = int'(out_c) + k % 3 - 1;
      if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W) begin
        off = latest - (rr * IMG_W + cc);
        for (int j = 0; j <= DEPTH; j++)
          if (off == j) tap[k] = cur[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sr[0] <= bus.in_data;
      for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc_cnt  <= '0;
      out_r    <= '0;
      out_c    <= '0;
      out_done <= 1'b0;
      valid_q  <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
    end else begin
      case (state)
        IDLE:    state <= STREAM;
        STREAM:  if (accept && acc_cnt == CW'(NPIX - 1)) state <= FLUSH;
        FLUSH:   if (last_xfer) state <= STREAM;
        default: state <= IDLE;
      endcase

      if (last_xfer)   acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + CW'(1);

      if (load) begin
        valid_q <= 1'b1;
        row_q   <= out_r;
        col_q   <= out_c;
        for (int k = 0; k < 9; k++) w_q[k] <= tap[k];
        if (out_c == CLW'(IMG_W - 1)) begin
          out_c <= '0;
          if (out_r == RW'(IMG_H - 1)) out_done <= 1'b1;
          else                         out_r    <= out_r + RW'(1);
        end else begin
          out_c <= out_c + CLW'(1);
        end
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      // Frame wrap: no IDLE gap, next pixel is (0,0).
      if (last_xfer) begin
        out_r    <= '0;
        out_c    <= '0;
        out_done <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.win_valid  = valid_q;
  assign bus.win_row    = row_q;
  assign bus.win_col    = col_q;
  assign bus.frame_done = last_xfer;
  assign bus.W1 = w_q[0];
  assign bus.W2 = w_q[1];
  assign bus.W3 = w_q[2];
  assign bus.W4 = w_q[3];
  assign bus.W5 = w_q[4];
  assign bus.W6 = w_q[5];
  assign bus.W7 = w_q[6];
  assign bus.W8 = w_q[7];
  assign bus.W9 = w_q[8];
endmodule
